// File: rtl/riscv_pkg.sv
// Shared pipeline definitions: datapath width default and MEM-stage FSM encoding.
package riscv_pkg;

   localparam int BIT_W_DEF = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } mem_state_t;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: captures write-back data, destination and enable on load_en.
module mem_wb_reg #(
   parameter int BIT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_en,
   input  logic [BIT_W-1:0] wb_data_d,
   input  logic [4:0]       rd_d,
   input  logic             regwr_d,
   output logic [BIT_W-1:0] wb_data,
   output logic [4:0]       rd_out,
   output logic             regwr_out
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wb_data   <= '0;
         rd_out    <= '0;
         regwr_out <= 1'b0;
      end else if (load_en) begin
         wb_data   <= wb_data_d;
         rd_out    <= rd_d;
         regwr_out <= regwr_d;
      end
   end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues one D-cache word access per instruction, buffers read data
// when the rest of the pipeline is held, and feeds the MEM/WB register.
module mem_stage
   import riscv_pkg::*;
#(
   parameter int BIT_W = BIT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [BIT_W-1:0] alu_result_in,
   input  logic [BIT_W-1:0] mem_wdata_in,
   input  logic [4:0]       rd_in,
   input  logic [BIT_W-1:0] pc_step_in,
   input  logic             memrd_in,
   input  logic             memwr_in,
   input  logic             mem2reg_in,
   input  logic             regwr_in,
   input  logic             jump_in,
   input  logic             stall_in,
   output logic             dmem_ren,
   output logic             dmem_wen,
   output logic [29:0]      dmem_addr,
   output logic [BIT_W-1:0] dmem_wdata,
   input  logic [BIT_W-1:0] dmem_rdata,
   input  logic             dmem_stall,
   output logic             mem_stall,
   output logic [BIT_W-1:0] fwd_mem_data,
   output logic [BIT_W-1:0] wb_data,
   output logic [4:0]       rd_out,
   output logic             regwr_out,
   output mem_state_t       state_dbg
);

   mem_state_t       state_q, state_d;
   logic [BIT_W-1:0] buf_q;
   logic [BIT_W-1:0] rdata_sel;
   logic [BIT_W-1:0] wb_d;
   logic             access;
   logic             ren_c, wen_c, stall_c;
   logic             commit, buf_en;
   logic             unused_addr_bits;

   assign access           = memrd_in | memwr_in;
   assign dmem_addr        = alu_result_in[31:2];
   assign unused_addr_bits = ^alu_result_in[1:0];
   assign dmem_wdata       = mem_wdata_in;
   assign fwd_mem_data     = jump_in ? pc_step_in : alu_result_in;
   assign state_dbg        = state_q;

   // Reset masks the strobes and stall combinationally so nothing leaks out mid-reset.
   assign dmem_ren  = rst_n & ren_c;
   assign dmem_wen  = rst_n & wen_c;
   assign mem_stall = rst_n & stall_c;

   always_comb begin
      state_d   = state_q;
      ren_c     = 1'b0;
      wen_c     = 1'b0;
      stall_c   = 1'b0;
      commit    = 1'b0;
      buf_en    = 1'b0;
      rdata_sel = dmem_rdata;
      case (state_q)
         ST_IDLE: begin
            if (access) begin
               ren_c   = memrd_in & ~memwr_in;
               wen_c   = memwr_in;
               stall_c = 1'b1;
               state_d = ST_WAIT;
            end else begin
               commit = !stall_in;
            end
         end
         ST_WAIT: begin
            if (dmem_stall) begin
               ren_c   = memrd_in & ~memwr_in;
               wen_c   = memwr_in;
               stall_c = 1'b1;
            end else if (!stall_in) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               buf_en  = 1'b1;
               state_d = ST_HOLD;
            end
         end
         ST_HOLD: begin
            // Access already finished; wait out the external hold using the buffered data.
            rdata_sel = buf_q;
            if (!stall_in) begin
               commit  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign wb_d = mem2reg_in ? rdata_sel : (jump_in ? pc_step_in : alu_result_in);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         if (buf_en) buf_q <= dmem_rdata;
      end
   end

   mem_wb_reg #(.BIT_W(BIT_W)) u_mem_wb_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_en   (commit),
      .wb_data_d (wb_d),
      .rd_d      (rd_in),
      .regwr_d   (regwr_in),
      .wb_data   (wb_data),
      .rd_out    (rd_out),
      .regwr_out (regwr_out)
   );

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: ALU pass-through, load/store latency, HOLD buffering, reset abort.
module tb_mem_stage;
   import riscv_pkg::*;

   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [W-1:0]  alu_result_in, mem_wdata_in, pc_step_in, dmem_rdata;
   logic [4:0]    rd_in;
   logic          memrd_in, memwr_in, mem2reg_in, regwr_in, jump_in, stall_in, dmem_stall;
   logic          dmem_ren, dmem_wen, mem_stall, regwr_out;
   logic [29:0]   dmem_addr;
   logic [W-1:0]  dmem_wdata, fwd_mem_data, wb_data;
   logic [4:0]    rd_out;
   mem_state_t    state_dbg;

   int n_cmp = 0;
   int n_err = 0;
   int issue_cnt = 0;
   int issue_base;

   mem_stage #(.BIT_W(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_result_in(alu_result_in), .mem_wdata_in(mem_wdata_in), .rd_in(rd_in),
      .pc_step_in(pc_step_in), .memrd_in(memrd_in), .memwr_in(memwr_in),
      .mem2reg_in(mem2reg_in), .regwr_in(regwr_in), .jump_in(jump_in),
      .stall_in(stall_in), .dmem_ren(dmem_ren), .dmem_wen(dmem_wen),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_stall(dmem_stall), .mem_stall(mem_stall), .fwd_mem_data(fwd_mem_data),
      .wb_data(wb_data), .rd_out(rd_out), .regwr_out(regwr_out), .state_dbg(state_dbg)
   );

   // clock / reset
   always #5 clk = ~clk;

   // Counts new requests: a strobe seen while still in IDLE starts a fresh access.
   always @(negedge clk)
      if (rst_n && state_dbg == ST_IDLE && (dmem_ren || dmem_wen)) issue_cnt <= issue_cnt + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic clear_inputs();
      alu_result_in = '0; mem_wdata_in = '0; pc_step_in = '0; rd_in = '0;
      memrd_in = 0; memwr_in = 0; mem2reg_in = 0; regwr_in = 0; jump_in = 0;
      stall_in = 0; dmem_stall = 0; dmem_rdata = '0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst_n = 0;
      memrd_in = 1; alu_result_in = 32'h0000_0100; regwr_in = 1; rd_in = 5'd3;
      tick(); tick();
      chk("rst_state", state_dbg, ST_IDLE);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_rd_out", rd_out, 0);
      chk("rst_regwr", regwr_out, 0);
      chk("rst_ren_forced", dmem_ren, 0);
      chk("rst_stall_forced", mem_stall, 0);
      clear_inputs();
      rst_n = 1;
      tick();
   endtask

   task automatic test_alu();
      clear_inputs(); tick();
      alu_result_in = 32'h0000_1234; rd_in = 5'd5; regwr_in = 1;
      #1;
      chk("alu_fwd", fwd_mem_data, 32'h1234);
      chk("alu_no_stall", mem_stall, 0);
      chk("alu_no_req", {dmem_ren, dmem_wen}, 0);
      tick();
      chk("alu_wb", wb_data, 32'h1234);
      chk("alu_rd", rd_out, 5);
      chk("alu_regwr", regwr_out, 1);
      chk("alu_no_stall2", mem_stall, 0);
   endtask

   task automatic test_load();
      clear_inputs(); tick();
      issue_base = issue_cnt;
      alu_result_in = 32'h100; memrd_in = 1; mem2reg_in = 1; regwr_in = 1; rd_in = 5'd7;
      #1;
      chk("ld_addr", dmem_addr, 30'h40);
      chk("ld_ren", dmem_ren, 1);
      chk("ld_wen", dmem_wen, 0);
      chk("ld_stall", mem_stall, 1);
      dmem_stall = 1;
      tick();
      for (int i = 0; i < 3; i++) begin
         chk("ld_wait_state", state_dbg, ST_WAIT);
         chk("ld_wait_ren", dmem_ren, 1);
         chk("ld_wait_stall", mem_stall, 1);
         chk("ld_wait_hold_regwr", regwr_out, 0);
         if (i < 2) tick();
         else begin
            tick();
            dmem_stall = 0; dmem_rdata = 32'hDEAD_BEEF;
            #1;
         end
      end
      chk("ld_done_ren", dmem_ren, 0);
      chk("ld_done_stall", mem_stall, 0);
      tick();
      clear_inputs();
      chk("ld_wb", wb_data, 32'hDEAD_BEEF);
      chk("ld_rd", rd_out, 7);
      chk("ld_regwr", regwr_out, 1);
      chk("ld_state_idle", state_dbg, ST_IDLE);
      tick();
      chk("ld_one_issue", issue_cnt - issue_base, 1);
   endtask

   task automatic test_store();
      clear_inputs(); tick();
      alu_result_in = 32'h204; mem_wdata_in = 32'hA5A5_A5A5; memwr_in = 1; rd_in = 5'd4;
      dmem_stall = 1;
      #1;
      chk("st_wen", dmem_wen, 1);
      chk("st_ren", dmem_ren, 0);
      chk("st_addr", dmem_addr, 30'h81);
      chk("st_wdata", dmem_wdata, 32'hA5A5_A5A5);
      tick();
      chk("st_wait_wen", dmem_wen, 1);
      chk("st_wait_ren", dmem_ren, 0);
      dmem_stall = 0;
      #1;
      chk("st_done_wen", dmem_wen, 0);
      tick();
      clear_inputs();
      chk("st_regwr", regwr_out, 0);
      chk("st_wb_alu", wb_data, 32'h204);
   endtask

   task automatic test_hold();
      clear_inputs(); tick();
      issue_base = issue_cnt;
      alu_result_in = 32'h300; memrd_in = 1; mem2reg_in = 1; regwr_in = 1; rd_in = 5'd9;
      tick();
      chk("hd_wait_state", state_dbg, ST_WAIT);
      stall_in = 1; dmem_rdata = 32'hCAFE_F00D;
      #1;
      chk("hd_wait_stall", mem_stall, 0);
      tick();
      dmem_rdata = 32'h1111_1111;
      for (int i = 0; i < 2; i++) begin
         #1;
         chk("hd_state", state_dbg, ST_HOLD);
         chk("hd_strobes", {dmem_ren, dmem_wen}, 0);
         chk("hd_stall", mem_stall, 0);
         chk("hd_wb_held", wb_data, 0);
         if (i == 0) tick();
      end
      stall_in = 0;
      tick();
      clear_inputs();
      chk("hd_wb", wb_data, 32'hCAFE_F00D);
      chk("hd_rd", rd_out, 9);
      chk("hd_idle", state_dbg, ST_IDLE);
      tick();
      chk("hd_one_issue", issue_cnt - issue_base, 1);
   endtask

   task automatic test_jal_and_stall();
      clear_inputs(); tick();
      jump_in = 1; pc_step_in = 32'h28; alu_result_in = 32'h400; regwr_in = 1; rd_in = 5'd1;
      #1;
      chk("jal_fwd", fwd_mem_data, 32'h28);
      tick();
      chk("jal_wb", wb_data, 32'h28);
      jump_in = 0; alu_result_in = 32'h777; rd_in = 5'd2; stall_in = 1;
      tick();
      chk("stl_wb_held", wb_data, 32'h28);
      chk("stl_rd_held", rd_out, 1);
      stall_in = 0;
      tick();
      chk("stl_wb_new", wb_data, 32'h777);
   endtask

   task automatic test_priority();
      clear_inputs(); tick();
      memrd_in = 1; memwr_in = 1; alu_result_in = 32'h10;
      #1;
      chk("pri_wen", dmem_wen, 1);
      chk("pri_ren", dmem_ren, 0);
      tick(); tick();
      clear_inputs(); tick();
   endtask

   task automatic test_reset_wait();
      clear_inputs(); tick();
      alu_result_in = 32'h500; memrd_in = 1; mem2reg_in = 1; regwr_in = 1; rd_in = 5'd6;
      dmem_stall = 1;
      tick();
      chk("rw_state", state_dbg, ST_WAIT);
      rst_n = 0;
      #1;
      chk("rw_ren_forced", dmem_ren, 0);
      chk("rw_stall_forced", mem_stall, 0);
      tick();
      chk("rw_idle", state_dbg, ST_IDLE);
      chk("rw_regwr", regwr_out, 0);
      clear_inputs();
      rst_n = 1;
      dmem_rdata = 32'h9999_9999;
      tick();
      tick();
      chk("rw_no_wb", wb_data, 0);
      chk("rw_no_regwr", regwr_out, 0);
   endtask

   initial begin
      clear_inputs();
      rst_n = 0;
      test_reset();
      test_alu();
      test_load();
      test_store();
      test_hold();
      test_jal_and_stall();
      test_priority();
      test_reset_wait();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: BIT_W, default 32, datapath width.
REQ-002 The block SHALL use clock clk and reset rst_n, synchronous, active-low:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
REQ-003 The block SHALL provide these EX/MEM register inputs:
- alu_result_in  in  BIT_W  ALU result / memory byte address
- mem_wdata_in  in  BIT_W  store data
- rd_in  in  5  destination register
- pc_step_in  in  BIT_W  PC+2/4 link value
- memrd_in, memwr_in, mem2reg_in, regwr_in, jump_in  in  1 each  control flags
REQ-004 The block SHALL provide this global hold input:
- stall_in  in  1  pipeline hold from other sources, e.g. I-cache
REQ-005 The block SHALL provide this data-cache port:
- dmem_ren, dmem_wen  out  1  request strobes
- dmem_addr  out  30  word address
- dmem_wdata  out  BIT_W  write data
- dmem_rdata  in  BIT_W  read data
- dmem_stall  in  1  cache busy
REQ-006 The block SHALL provide these outputs:
- mem_stall  out  1  stage busy, freezes IF/ID/EX
- fwd_mem_data  out  BIT_W  unregistered forwarding value to EX
- wb_data  out  BIT_W  MEM/WB write-back data
- rd_out  out  5  MEM/WB destination register
- regwr_out  out  1  MEM/WB write enable

Function
REQ-007 access = memrd_in | memwr_in.
REQ-008 advance = !stall_in & !mem_stall.
REQ-009 dmem_addr SHALL equal alu_result_in[31:2]; bits [1:0] are ignored (word accesses only).
REQ-010 dmem_wdata SHALL equal mem_wdata_in.
REQ-011 The FSM SHALL have states IDLE, WAIT and HOLD.
REQ-012 IDLE, access=1:
- dmem_ren=memrd_in, dmem_wen=memwr_in, mem_stall=1
- next state WAIT
REQ-013 IDLE, access=0:
- no request, mem_stall=0
- MEM/WB loads from inputs on advance
REQ-014 WAIT, dmem_stall=1:
- hold the request strobes and mem_stall=1
- remain in WAIT
REQ-015 WAIT, dmem_stall=0:
- deassert strobes, mem_stall=0
- stall_in=0: MEM/WB captures the result directly; next state IDLE
- stall_in=1: latch dmem_rdata into an internal buffer; next state HOLD
REQ-016 HOLD:
- no request, mem_stall=0
- on stall_in=0: MEM/WB takes buffered data; next state IDLE
- no access is ever re-issued for an instruction already completed.
REQ-017 Write-back select:
- mem2reg_in=1: read data
- else jump_in=1: pc_step_in
- else: alu_result_in
REQ-018 fwd_mem_data SHALL be (jump_in ? pc_step_in : alu_result_in), combinational; load-use hazards are resolved elsewhere.
REQ-019 When advance=0 and no HOLD commit occurs, wb_data, rd_out and regwr_out SHALL hold their values.
REQ-020 Minimum access latency SHALL be two cycles: request cycle plus one WAIT cycle with dmem_stall=0.
REQ-021 dmem_ren and dmem_wen SHALL never be high simultaneously; if both flags are set, memwr_in has priority.

Reset
REQ-022 While rst_n=0 at a clock edge, the block SHALL:
- set state=IDLE
- clear wb_data, rd_out, regwr_out and the buffer to 0
REQ-023 While rst_n=0, dmem_ren, dmem_wen and mem_stall SHALL be forced to 0.
REQ-024 Reset during WAIT or HOLD SHALL abandon the access; no write-back occurs afterwards.

Structure
REQ-025 The FSM state encoding and BIT_W default SHALL reside in the shared riscv_pkg package.
REQ-026 There SHALL be a single module with no mandatory sub-module; the MEM/WB register may be split out as mem_wb_reg.

Verification
REQ-027 ALU op: alu=0x0000_1234, rd=5, regwr=1, no access → next edge: wb_data=0x1234, rd_out=5, regwr_out=1, mem_stall never asserted.
REQ-028 Load with alu=0x100:
- dmem_addr=0x40, dmem_ren=1, mem_stall=1
- dmem_stall=1 for 3 cycles, then 0 with rdata=0xDEADBEEF
- expect wb_data=0xDEADBEEF, exactly one request sequence
REQ-029 Store with alu=0x204 and wdata=0xA5A5A5A5:
- dmem_wen=1, dmem_addr=0x81, dmem_wdata=0xA5A5A5A5, dmem_ren=0 throughout
- expect regwr_out=0
REQ-030 Load completing while stall_in=1 for 2 more cycles:
- FSM enters HOLD, strobes stay 0
- after stall_in drops: wb_data=buffered rdata, no second request
REQ-031 JAL with pc_step=0x28, alu=0x400 → fwd_mem_data=0x28 and wb_data=0x28.
REQ-032 rst_n=0 asserted in WAIT → next cycle state IDLE, strobes 0, regwr_out=0.
